// File: rtl/eth_udp_strip.sv
// eth_udp_strip: Ethernet/IPv4/UDP header filter and stripper.
// Accepts raw frames on a 64-bit non-stallable stream. Frames are checked on
// EtherType, IPv4 version/IHL, fragmentation, protocol and UDP destination port.
// The 42-byte header is removed and the payload realigned to lane 0.
// Rejected and runt frames bump a saturating drop counter.
module eth_udp_strip #(
  parameter int          AXI_DATA_W = 64,
  parameter int          AXI_KEEP_W = AXI_DATA_W/8,
  parameter logic [15:0] UDP_PORT   = 16'd18000,
  parameter int          DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  mac_axis_tvalid_i,
  input  logic [AXI_DATA_W-1:0] mac_axis_tdata_i,
  input  logic [AXI_KEEP_W-1:0] mac_axis_tkeep_i,
  input  logic                  mac_axis_tlast_i,
  input  logic                  mac_axis_tuser_i,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic                  udp_axis_tlast_o,
  output logic                  udp_axis_tuser_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP, S_TAIL} state_t;

  // Thermometer keep with the n lowest lanes set.
  function automatic logic [7:0] therm(input logic [3:0] n);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (4'(i) < n);
    return t;
  endfunction

  // Expand a per-lane keep into a per-bit data mask.
  function automatic logic [63:0] lane_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t        r_state, w_state;
  logic [2:0]    r_cnt, w_cnt;
  logic          r_first, w_first;
  logic [47:0]   r_hold, w_hold;
  logic [7:0]    r_tail_keep, w_tail_keep;
  logic          r_tail_user, w_tail_user;

  logic          r_vld, w_vld;
  logic [63:0]   r_data, w_data, w_raw;
  logic [7:0]    r_keep, w_keep;
  logic          r_last, w_last;
  logic          r_user, w_user;
  logic          w_drop;
  logic [DROP_CNT_W-1:0] r_drop;

  logic [63:0]   w_d;
  logic [3:0]    w_n;
  logic [2:0]    w_cnt_eff;
  logic          w_ok;
  logic [63:0]   w_full;

  assign w_d    = mac_axis_tdata_i;
  assign w_full = {w_d[15:0], r_hold};
  // A beat arriving during TAIL is the next frame's beat0.
  assign w_cnt_eff = (r_state == S_TAIL) ? 3'd0 : r_cnt;

  // Valid byte count of the current input beat.
  always_comb begin
    w_n = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) w_n = w_n + 4'(mac_axis_tkeep_i[i]);
  end

  // Per-beat header check for the current header beat index.
  always_comb begin
    case (w_cnt_eff)
      3'd1:    w_ok = (w_d[39:32] == 8'h08) && (w_d[47:40] == 8'h00) && (w_d[55:48] == 8'h45);
      3'd2:    w_ok = (({w_d[39:32], w_d[47:40]} & 16'h3FFF) == 16'h0) && (w_d[63:56] == 8'h11);
      3'd4:    w_ok = ({w_d[39:32], w_d[47:40]} == UDP_PORT);
      default: w_ok = 1'b1;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_first     = r_first;
    w_hold      = r_hold;
    w_tail_keep = r_tail_keep;
    w_tail_user = r_tail_user;
    w_vld       = 1'b0;
    w_raw       = '0;
    w_keep      = '0;
    w_last      = 1'b0;
    w_user      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_HDR, S_TAIL: begin
        if (r_state == S_TAIL) begin
          w_vld   = 1'b1;
          w_raw   = {16'h0, r_hold};
          w_keep  = r_tail_keep;
          w_last  = 1'b1;
          w_user  = r_tail_user;
          w_state = S_HDR;
          w_cnt   = '0;
        end
        if (mac_axis_tvalid_i) begin
          if (mac_axis_tlast_i) begin
            w_drop  = 1'b1;
            w_state = S_HDR;
            w_cnt   = '0;
          end else if (!w_ok) begin
            w_state = S_DROP;
            w_cnt   = '0;
          end else if (w_cnt_eff == 3'd4) begin
            w_state = S_PAY;
            w_first = 1'b1;
            w_cnt   = '0;
          end else begin
            w_cnt = w_cnt_eff + 3'd1;
          end
        end
      end
      S_PAY: begin
        if (mac_axis_tvalid_i) begin
          if (r_first) begin
            // Beat5 holds payload bytes 0..5 in lanes 2..7.
            w_first = 1'b0;
            if (mac_axis_tlast_i) begin
              w_state = S_HDR;
              if (w_n > 4'd2) begin
                w_vld  = 1'b1;
                w_raw  = w_d >> 16;
                w_keep = therm(w_n - 4'd2);
                w_last = 1'b1;
                w_user = mac_axis_tuser_i;
              end
            end else begin
              w_hold = w_d[63:16];
            end
          end else if (!mac_axis_tlast_i) begin
            w_vld  = 1'b1;
            w_raw  = w_full;
            w_keep = 8'hFF;
            w_hold = w_d[63:16];
          end else if (w_n <= 4'd2) begin
            w_vld   = 1'b1;
            w_raw   = w_full;
            w_keep  = therm(w_n + 4'd6);
            w_last  = 1'b1;
            w_user  = mac_axis_tuser_i;
            w_state = S_HDR;
          end else begin
            // Last beat overflows one output beat: remainder goes out from TAIL.
            w_vld       = 1'b1;
            w_raw       = w_full;
            w_keep      = 8'hFF;
            w_hold      = w_d[63:16] & lane_mask(therm(w_n - 4'd2))[47:0];
            w_tail_keep = therm(w_n - 4'd2);
            w_tail_user = mac_axis_tuser_i;
            w_state     = S_TAIL;
          end
        end
      end
      S_DROP: begin
        if (mac_axis_tvalid_i && mac_axis_tlast_i) begin
          w_drop  = 1'b1;
          w_state = S_HDR;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_HDR;
        w_cnt   = '0;
      end
    endcase
    w_data = w_raw & lane_mask(w_keep);
  end

  // State, hold and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_HDR;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_hold      <= '0;
      r_tail_keep <= '0;
      r_tail_user <= 1'b0;
      r_vld       <= 1'b0;
      r_data      <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
      r_user      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_first     <= w_first;
      r_hold      <= w_hold;
      r_tail_keep <= w_tail_keep;
      r_tail_user <= w_tail_user;
      r_vld       <= w_vld;
      r_data      <= w_data;
      r_keep      <= w_keep;
      r_last      <= w_last;
      r_user      <= w_user;
    end
  end

  // Saturating dropped-frame counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                   r_drop <= '0;
    else if (w_drop && ~&r_drop)   r_drop <= r_drop + DROP_CNT_W'(1);
  end

  assign udp_axis_tvalid_o = r_vld;
  assign udp_axis_tdata_o  = r_data;
  assign udp_axis_tkeep_o  = r_keep;
  assign udp_axis_tlast_o  = r_last;
  assign udp_axis_tuser_o  = r_user;
  assign drop_cnt_o        = r_drop;

endmodule

// File: tb/tb_eth_udp_strip.sv
// Randomized bench for eth_udp_strip with a frame-level reference model:
// accepted frames produce the payload chunked into 8-byte beats, everything
// else bumps a saturating drop count.
module tb_eth_udp_strip;
  localparam logic [15:0] PORT = 16'd18000;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        tv = 1'b0, tl = 1'b0, tu = 1'b0;
  logic [63:0] td = '0;
  logic [7:0]  tk = '0;
  logic        o_vld, o_last, o_user;
  logic [63:0] o_data;
  logic [7:0]  o_keep;
  logic [15:0] o_drop;

  always #5 clk = ~clk;

  eth_udp_strip #(.AXI_DATA_W(64), .AXI_KEEP_W(8), .UDP_PORT(PORT), .DROP_CNT_W(16)) dut (
    .clk(clk), .nreset(nreset),
    .mac_axis_tvalid_i(tv), .mac_axis_tdata_i(td), .mac_axis_tkeep_i(tk),
    .mac_axis_tlast_i(tl), .mac_axis_tuser_i(tu),
    .udp_axis_tvalid_o(o_vld), .udp_axis_tdata_o(o_data), .udp_axis_tkeep_o(o_keep),
    .udp_axis_tlast_o(o_last), .udp_axis_tuser_o(o_user), .drop_cnt_o(o_drop)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    int          c;
  } beat_t;

  int          cyc = 0;
  int          n_vec = 0, n_bad = 0;
  int          model_drop = 0;
  beat_t       obs[$], exp_q[$];
  beat_t       mb;
  logic [7:0]  frm[$], pay[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output beat with the cycle it was presented in.
  always @(negedge clk) begin
    if (o_vld) begin
      mb.d = o_data; mb.k = o_keep; mb.l = o_last; mb.u = o_user; mb.c = cyc;
      obs.push_back(mb);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tv = 1'b0; tl = 1'b0; tu = 1'b0; td = '0; tk = '0;
    end
  endtask

  task automatic build(input int plen, input logic [15:0] etype, input logic [7:0] verihl,
                       input logic [15:0] frag, input logic [7:0] proto, input logic [15:0] port);
    logic [15:0] tot;
    frm.delete(); pay.delete();
    tot = 16'(28 + plen);
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(verihl); frm.push_back(8'($urandom));
    frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    frm.push_back(frag[15:8]); frm.push_back(frag[7:0]);
    frm.push_back(8'($urandom)); frm.push_back(proto);
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    frm.push_back(port[15:8]); frm.push_back(port[7:0]);
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      frm.push_back(b); pay.push_back(b);
    end
  endtask

  // Frame-level acceptance rule taken from the header fields.
  function automatic bit accept();
    if (frm.size() < 42) return 1'b0;
    return ({frm[12], frm[13]} == 16'h0800) && (frm[14] == 8'h45) &&
           ((({frm[20], frm[21]}) & 16'h3FFF) == 16'h0) && (frm[23] == 8'h11) &&
           ({frm[36], frm[37]} == PORT);
  endfunction

  task automatic drive_beat(input int b, input bit last, input logic user, output int st);
    logic [63:0] d;
    logic [7:0]  k;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = 8*b + i;
      if (idx < frm.size()) begin d[8*i +: 8] = frm[idx]; k[i] = 1'b1; end
      else begin d[8*i +: 8] = 8'($urandom); k[i] = 1'b0; end
    end
    @(negedge clk);
    tv = 1'b1; td = d; tk = k; tl = last;
    tu = last ? user : 1'($urandom);
    @(posedge clk);
    #1 st = cyc;
  endtask

  task automatic drive(input logic user, input bit gaps);
    int L, P, nb;
    int st[16];
    bit acc;
    L = (frm.size() - 1) / 8;
    acc = accept();
    for (int b = 0; b <= L; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      drive_beat(b, b == L, user, st[b]);
    end
    if (acc) begin
      P  = pay.size();
      nb = (P + 7) / 8;
      for (int j = 0; j < nb; j++) begin
        beat_t e;
        int src;
        bit tail;
        e.d = '0; e.k = '0;
        for (int i = 0; i < 8; i++)
          if (8*j + i < P) begin e.d[8*i +: 8] = pay[8*j + i]; e.k[i] = 1'b1; end
        e.l = (j == nb - 1);
        e.u = e.l ? user : 1'b0;
        src  = 6 + j;
        tail = (src > L) && (L > 5);
        if (src > L) src = L;
        e.c = st[src] + (tail ? 1 : 0);
        exp_q.push_back(e);
      end
    end else if (model_drop < 16'hFFFF) begin
      model_drop++;
    end
  endtask

  task automatic flush(input string tag);
    int n;
    idle(4);
    chk($sformatf("%s.nbeats", tag), 64'(obs.size()), 64'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.b%0d.data", tag, i), obs[i].d, exp_q[i].d);
      chk($sformatf("%s.b%0d.keep", tag, i), 64'(obs[i].k), 64'(exp_q[i].k));
      chk($sformatf("%s.b%0d.last", tag, i), 64'(obs[i].l), 64'(exp_q[i].l));
      chk($sformatf("%s.b%0d.user", tag, i), 64'(obs[i].u), 64'(exp_q[i].u));
      chk($sformatf("%s.b%0d.cyc", tag, i), 64'(obs[i].c), 64'(exp_q[i].c));
    end
    obs.delete(); exp_q.delete();
    chk($sformatf("%s.drop", tag), 64'(o_drop), 64'(model_drop));
  endtask

  task automatic runts(input int n);
    @(negedge clk);
    tv = 1'b1; tl = 1'b1; tk = 8'hFF; td = 64'($urandom);
    repeat (n) @(posedge clk);
    model_drop = (model_drop + n > 16'hFFFF) ? 16'hFFFF : model_drop + n;
    idle(2);
  endtask

  initial begin
    int dummy;
    // Reset state
    idle(3);
    chk("rst.vld", 64'(o_vld), 64'd0);
    chk("rst.data", o_data, 64'd0);
    chk("rst.drop", 64'(o_drop), 64'd0);
    @(negedge clk) nreset = 1'b1;
    idle(2);

    // Directed frames
    build(24, 16'h0800, 8'h45, 16'h4000, 8'h11, PORT);       drive(1'b0, 1'b0); flush("p24");
    build(24, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT + 16'd1); drive(1'b0, 1'b0); flush("badport");
    build(24, 16'h86DD, 8'h45, 16'h0000, 8'h11, PORT);       drive(1'b0, 1'b0); flush("badetype");
    build(24, 16'h0800, 8'h45, 16'h0000, 8'h06, PORT);       drive(1'b0, 1'b0); flush("badproto");
    build(30, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT);       drive(1'b1, 1'b0);
    build(24, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT);       drive(1'b0, 1'b0); flush("p30b2b");
    build(3,  16'h0800, 8'h45, 16'h0000, 8'h11, PORT);       drive(1'b0, 1'b0); flush("p3");
    build(0,  16'h0800, 8'h45, 16'h0000, 8'h11, PORT);       drive(1'b0, 1'b0); flush("p0");
    build(24, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT);
    frm = frm[0:31];                                          drive(1'b0, 1'b0); flush("runt");

    // Randomized frames with input gaps
    for (int f = 0; f < 60; f++) begin
      int kind, plen;
      logic [15:0] et, fr, pt;
      logic [7:0]  vi, pr;
      kind = $urandom_range(0, 9);
      plen = $urandom_range(0, 40);
      et = 16'h0800; vi = 8'h45; pr = 8'h11; pt = PORT;
      fr = ($urandom_range(0, 1) != 0) ? 16'h4000 : 16'h0000;
      case (kind)
        0: pt = PORT ^ 16'(1 << $urandom_range(0, 15));
        1: et = 16'h86DD;
        2: vi = 8'h46;
        3: fr = 16'($urandom_range(1, 16'h3FFF));
        4: pr = 8'h06;
        default: ;
      endcase
      build(plen, et, vi, fr, pr, pt);
      if (kind == 5) frm = frm[0:$urandom_range(0, 39)];
      drive(1'($urandom), 1'b1);
      flush($sformatf("rnd%0d", f));
    end

    // Drop counter saturation
    runts(16'hFFFE - model_drop);
    chk("sat.fffe", 64'(o_drop), 64'(model_drop));
    runts(3);
    chk("sat.ffff", 64'(o_drop), 64'(model_drop));

    // Asynchronous reset during beat 7 of a valid frame
    build(24, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT);
    for (int b = 0; b < 7; b++) drive_beat(b, 1'b0, 1'b0, dummy);
    @(negedge clk);
    tv = 1'b1; tl = 1'b0; td = 64'($urandom); tk = 8'hFF;
    chk("prerst.vld", 64'(o_vld), 64'd1);
    #1 nreset = 1'b0;
    #1;
    chk("midrst.vld", 64'(o_vld), 64'd0);
    chk("midrst.data", o_data, 64'd0);
    chk("midrst.keep", 64'(o_keep), 64'd0);
    chk("midrst.last", 64'(o_last), 64'd0);
    chk("midrst.drop", 64'(o_drop), 64'd0);
    idle(1);
    nreset = 1'b1;
    obs.delete(); exp_q.delete(); model_drop = 0;
    idle(2);
    build(21, 16'h0800, 8'h45, 16'h0000, 8'h11, PORT); drive(1'b1, 1'b0); flush("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
